uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver. Successor to the fixed 8N1 single-tick receiver.
- Adds:
  - configurable data width, parity and stop bits;
  - 2-flop input synchroniser;
  - mid-bit sampling with false-start rejection;
  - framing, parity, overrun and break detection;
  - valid/ready output holding register.
- Sits between the async rxd pin and the consumer logic that takes bytes.

Parameters:
- CLK_DIV, 13: clk cycles per oversample tick (tick = OVERSAMPLE x baud); legal >= 2.
- OVERSAMPLE, 16: ticks per bit; even, >= 8.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY_EN, 0: 1 = parity bit expected after data.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rxd  in  1  serial input, asynchronous, idles high.
- data_out  out  DATA_BITS  received word, valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts data_out when rx_valid && rx_ready at posedge clk.
- parity_err  out  1  parity mismatch for data_out; qualified by rx_valid.
- frame_err  out  1  a stop bit sampled 0 for data_out; qualified by rx_valid.
- overrun  out  1  one-cycle pulse: frame completed while holding register full and not being read; new frame discarded.
- break_det  out  1  one-cycle pulse on break detection.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - synchroniser flops = 1, FSM = IDLE, all counters = 0.
  - data_out = 0; rx_valid, parity_err, frame_err, overrun, break_det, busy = 0.
  - Reset mid-frame abandons the frame silently.
- Synchroniser: rxd_s = 2-flop resynchronised rxd. All decisions use rxd_s (2-clk input latency).
- Tick generator:
  - free-running counter 0..CLK_DIV-1; tick=1 in the cycle the counter = CLK_DIV-1.
  - not reset by frame activity.
- Tick counter s_cnt: 0..OVERSAMPLE-1. Bit counter b_cnt: 0..DATA_BITS-1.
- FSM states and transitions:
  - IDLE: rxd_s=0 -> START, s_cnt=0.
  - START: on tick, s_cnt++. When s_cnt reaches OVERSAMPLE/2-1, sample rxd_s:
    - 1 -> IDLE (glitch, no outputs);
    - 0 -> DATA, s_cnt=0, b_cnt=0.
  - DATA: on tick, s_cnt++. At s_cnt=OVERSAMPLE-1 (mid-bit):
    - shift rxd_s into shift register MSB end (LSB first on the line); s_cnt=0.
    - if b_cnt=DATA_BITS-1 -> PARITY (if PARITY_EN) else STOP; else b_cnt++.
  - PARITY: mid-bit sample p. Error if (XOR of data ^ p) != PARITY_ODD. -> STOP.
  - STOP: mid-bit sample of each of STOP_BITS stop bits; any 0 sets frame error.
    - After the last stop sample, complete the frame and go to IDLE.
    - Break exception: data all 0, parity bit (if any) 0 and first stop bit 0 -> BRK_WAIT instead; no frame delivered.
  - BRK_WAIT: break_det pulses on entry. Stay until rxd_s=1, then -> IDLE.
- Frame completion (cycle after the tick of the last stop sample):
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle -> load data_out, parity_err, frame_err; rx_valid=1. Simultaneous accept + load is not an overrun.
  - otherwise overrun=1 for one cycle; holding register and flags unchanged.
- Handshake:
  - rx_valid && rx_ready clears rx_valid next clk unless a new frame loads in that cycle.
  - data_out and flags stable while rx_valid=1.
- Latency: rx_valid rises 1 clk after the tick at mid-sample of the last stop bit, plus the 2-clk synchroniser delay from the line.
- Widths:
  - s_cnt width = clog2(OVERSAMPLE); b_cnt width = clog2(DATA_BITS).
  - parity_err is forced 0 when PARITY_EN=0.
- After a framing error the FSM returns to IDLE. If rxd_s is still 0 it re-enters START next cycle.

Test Plan:
1. CLK_DIV=4, OVERSAMPLE=16, 8N1, send 0xA5, rx_ready=1 -> rx_valid pulses one cycle with data_out=0xA5; parity_err=0, frame_err=0, busy returns to 0.
2. PARITY_EN=1 even:
   - 0xA5 with parity bit 0 -> parity_err=0.
   - Repeat with parity bit 1 -> parity_err=1, data_out=0xA5.
   - PARITY_ODD=1, 0x01 with parity bit 0 -> parity_err=0.
3. Low glitch on rxd of 3 ticks (12 clks), then high -> FSM returns to IDLE, no rx_valid, busy low again within OVERSAMPLE/2 ticks.
4. Framing and break:
   - 0x3C with stop bit 0 -> rx_valid=1, data_out=0x3C, frame_err=1.
   - rxd held 0 for 12 bit times -> break_det single pulse, no rx_valid. After rxd returns high, a following 0x55 is received correctly.
5. Backpressure:
   - rx_ready=0; send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once at the 0x22 completion.
   - Repeat with rx_ready asserted exactly in the 0x22 completion cycle -> no overrun, data_out=0x22, rx_valid stays 1.
6. STOP_BITS=2, DATA_BITS=7: 0x5A with second stop bit 0 -> frame_err=1. Separately, reset=0 asserted mid-DATA -> all outputs 0 immediately (async). After release, the next frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable data/parity/stop framing, mid-bit
// sampling with false-start rejection, error/break detection, valid/ready output.
module uart_rx_os #(
  parameter int CLK_DIV    = 13,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  // state    | meaning
  // IDLE     | line idle, waiting for rxd_s low
  // START    | counting to mid start bit, rejecting glitches
  // DATA     | sampling data bits, LSB first
  // PARITY   | sampling the parity bit
  // STOP     | sampling stop bit(s), delivering the frame
  // BRK_WAIT | break seen, waiting for the line to return high

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [S_W-1:0]   S_HALF    = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST    = B_W'(DATA_BITS - 1);
  localparam logic             PAR_EN    = (PARITY_EN != 0);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [S_W-1:0]       s_cnt_q, s_cnt_d;
  logic [B_W-1:0]       b_cnt_q, b_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 break_det_q, break_det_d;
  logic                 busy_q, busy_d;

  logic rxd_s;
  logic tick;
  logic ferr_next;
  logic brk_cond;
  logic complete;

  assign rxd_s     = sync2_q;
  assign tick      = (div_q == DIV_LAST);
  assign ferr_next = ferr_acc_q | ~rxd_s;
  // A break is an all-zero frame whose parity (if any) and first stop are also 0.
  assign brk_cond  = (shift_q == '0) && !rxd_s && !(PAR_EN && par_bit_q);

  always_comb begin
    sync1_d      = rxd;
    sync2_d      = sync1_q;
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    b_cnt_d      = b_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shift_d      = shift_q;
    perr_acc_d   = perr_acc_q;
    par_bit_d    = par_bit_q;
    ferr_acc_d   = ferr_acc_q;
    complete     = 1'b0;
    break_det_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d    = START;
          s_cnt_d    = '0;
          b_cnt_d    = '0;
          stop_cnt_d = 1'b0;
          perr_acc_d = 1'b0;
          par_bit_d  = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == S_HALF) begin
            s_cnt_d = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (b_cnt_q == B_LAST) begin
              state_d = PAR_EN ? PARITY : STOP;
            end else begin
              b_cnt_d = b_cnt_q + B_W'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d    = '0;
            par_bit_d  = rxd_s;
            perr_acc_d = ((^shift_q) ^ rxd_s) != PAR_ODD;
            state_d    = STOP;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            if (!stop_cnt_q && brk_cond) begin
              state_d     = BRK_WAIT;
              break_det_d = 1'b1;
            end else if (stop_cnt_q == STOP_LAST) begin
              complete = 1'b1;
              state_d  = IDLE;
            end else begin
              stop_cnt_d = 1'b1;
              ferr_acc_d = ferr_next;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      BRK_WAIT: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    // Accept and reload in the same cycle is legal; only a blocked load overruns.
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        data_out_d   = shift_q;
        parity_err_d = PAR_EN & perr_acc_q;
        frame_err_d  = ferr_next;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      div_q        <= '0;
      s_cnt_q      <= '0;
      b_cnt_q      <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      par_bit_q    <= 1'b0;
      ferr_acc_q   <= 1'b0;
      data_out_q   <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      div_q        <= div_d;
      s_cnt_q      <= s_cnt_d;
      b_cnt_q      <= b_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      perr_acc_q   <= perr_acc_d;
      par_bit_q    <= par_bit_d;
      ferr_acc_q   <= ferr_acc_d;
      data_out_q   <= data_out_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: four configurations share one clock; a
// monitor pops expected events whenever a unit accepts data or pulses a flag.
module tb_uart_rx_os;
  localparam int CLK_DIV  = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_DIV * OS;
  localparam int K_DATA   = 0;
  localparam int K_OVR    = 1;
  localparam int K_BRK    = 2;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] kind;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rxd_r;
  logic [3:0] rdy;
  wire  [3:0] vld, perr, ferr, ovr, brk, bsy;
  wire  [7:0] dout [4];
  wire  [6:0] dout_d;
  int         tb_div;
  exp_t       sbq[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // unit 0: 8N1, unit 1: 8E1, unit 2: 8O1, unit 3: 7N2
  uart_rx_os #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(0),
               .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(rst_n), .rxd(rxd_r[0]), .data_out(dout[0]), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]),
    .break_det(brk[0]), .busy(bsy[0]));
  uart_rx_os #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1),
               .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(rst_n), .rxd(rxd_r[1]), .data_out(dout[1]), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]),
    .break_det(brk[1]), .busy(bsy[1]));
  uart_rx_os #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1),
               .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(rst_n), .rxd(rxd_r[2]), .data_out(dout[2]), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]),
    .break_det(brk[2]), .busy(bsy[2]));
  uart_rx_os #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY_EN(0),
               .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .clk(clk), .reset(rst_n), .rxd(rxd_r[3]), .data_out(dout_d), .rx_valid(vld[3]),
    .rx_ready(rdy[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]),
    .break_det(brk[3]), .busy(bsy[3]));
  assign dout[3] = {1'b0, dout_d};

  // Free-running tick phase, used only to place rx_ready on a chosen tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_div <= 0;
    else        tb_div <= (tb_div == CLK_DIV - 1) ? 0 : tb_div + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int kind, input logic [7:0] d,
                      input logic pe, input logic fe);
    exp_t e;
    e.id = 2'(id); e.kind = 2'(kind); e.data = d; e.pe = pe; e.fe = fe;
    sbq.push_back(e);
  endtask

  task automatic mon_event(input int i, input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: got event kind %0d on unit %0d, expected none", kind, i);
    end else begin
      e = sbq.pop_front();
      chk("sb_unit", 32'(i), 32'(e.id));
      chk("sb_kind", 32'(kind), 32'(e.kind));
      if (kind == K_DATA) begin
        chk("sb_data", 32'(dout[i]), 32'(e.data));
        chk("sb_parity_err", 32'(perr[i]), 32'(e.pe));
        chk("sb_frame_err", 32'(ferr[i]), 32'(e.fe));
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ovr[i]) mon_event(i, K_OVR);
        if (brk[i]) mon_event(i, K_BRK);
        if (vld[i] && rdy[i]) mon_event(i, K_DATA);
      end
    end
  end

  task automatic drive_bit(input int id, input logic v, input int clks);
    rxd_r[id] = v;
    repeat (clks) @(negedge clk);
  endtask

  // A zero final stop bit is cut short so the line is high again before the
  // receiver's restarted start-bit check samples it.
  task automatic send_frame(input int id, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par, input int nstop,
                            input logic [1:0] stp);
    drive_bit(id, 1'b0, BIT_CLKS);
    for (int i = 0; i < nbits; i++) drive_bit(id, data[i], BIT_CLKS);
    if (has_par) drive_bit(id, par, BIT_CLKS);
    for (int s = 0; s < nstop; s++)
      drive_bit(id, stp[s], (s == nstop - 1 && !stp[s]) ? BIT_CLKS * 3 / 4 : BIT_CLKS);
    rxd_r[id] = 1'b1;
  endtask

  task automatic idle(input int bits);
    repeat (bits * BIT_CLKS) @(negedge clk);
  endtask

  // Raise rx_ready for exactly the cycle of the target tick after frame start.
  task automatic ready_on_tick(input int id, input int target);
    int cnt = 0;
    bit is_tick;
    bit done = 0;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 4 * BIT_CLKS * 12 && !done; c++) begin
      @(negedge clk);
      is_tick = (tb_div == CLK_DIV - 1);
      if (is_tick && cnt == target - 1) rdy[id] = 1'b1;
      @(posedge clk);
      if (is_tick) cnt++;
      if (cnt == target) begin
        @(negedge clk);
        rdy[id] = 1'b0;
        chk("bp_same_cycle_valid", 32'(vld[id]), 32'(1));
        chk("bp_same_cycle_data", 32'(dout[id]), 32'h22);
        done = 1;
      end
    end
    if (!done) chk("bp_tick_timeout", 32'(cnt), 32'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rxd_r = 4'b1111;
    rdy   = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(vld), 32'h0);
    chk("rst_busy", 32'(bsy), 32'h0);
    chk("rst_flags", 32'({perr, ferr, ovr, brk}), 32'h0);
    for (int i = 0; i < 4; i++) chk("rst_data", 32'(dout[i]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // basic 8N1
    push(0, K_DATA, 8'hA5, 1'b0, 1'b0);
    fork
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
      begin repeat (3 * BIT_CLKS) @(negedge clk); #1; chk("busy_mid_frame", 32'(bsy[0]), 32'(1)); end
    join
    idle(1);
    #1;
    chk("busy_after_frame", 32'(bsy[0]), 32'(0));
    chk("valid_one_cycle", 32'(vld[0]), 32'(0));

    // parity
    push(1, K_DATA, 8'hA5, 1'b0, 1'b0);
    @(negedge clk); send_frame(1, 9'h0A5, 8, 1, 1'b0, 1, 2'b11); idle(1);
    push(1, K_DATA, 8'hA5, 1'b1, 1'b0);
    send_frame(1, 9'h0A5, 8, 1, 1'b1, 1, 2'b11); idle(1);
    push(2, K_DATA, 8'h01, 1'b0, 1'b0);
    send_frame(2, 9'h001, 8, 1, 1'b0, 1, 2'b11); idle(1);
    push(2, K_DATA, 8'h01, 1'b1, 1'b0);
    send_frame(2, 9'h001, 8, 1, 1'b1, 1, 2'b11); idle(1);

    // false start
    rxd_r[0] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("glitch_busy", 32'(bsy[0]), 32'(1));
    repeat (6) @(negedge clk);
    rxd_r[0] = 1'b1;
    repeat (OS / 2 * CLK_DIV) @(negedge clk);
    #1;
    chk("glitch_idle", 32'(bsy[0]), 32'(0));
    @(negedge clk);

    // framing error and break
    push(0, K_DATA, 8'h3C, 1'b0, 1'b1);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00); idle(2);
    push(0, K_BRK, 8'h00, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 12 * BIT_CLKS);
    rxd_r[0] = 1'b1;
    idle(2);
    #1;
    chk("break_released", 32'(bsy[0]), 32'(0));
    @(negedge clk);
    push(0, K_DATA, 8'h55, 1'b0, 1'b0);
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b11); idle(1);

    // backpressure with overrun
    rdy[0] = 1'b0;
    push(0, K_OVR, 8'h00, 1'b0, 1'b0);
    push(0, K_DATA, 8'h11, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11); idle(1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11); idle(1);
    #1;
    chk("ovr_hold_valid", 32'(vld[0]), 32'(1));
    chk("ovr_hold_data", 32'(dout[0]), 32'h11);
    @(negedge clk); rdy[0] = 1'b1;
    @(negedge clk); rdy[0] = 1'b0;
    #1;
    chk("ovr_drained", 32'(vld[0]), 32'(0));

    // accept and reload in the completion cycle
    @(negedge clk);
    push(0, K_DATA, 8'h11, 1'b0, 1'b0);
    push(0, K_DATA, 8'h22, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11); idle(1);
    fork
      send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11);
      ready_on_tick(0, OS / 2 + OS * 9);
    join
    idle(1);
    @(negedge clk); rdy[0] = 1'b1;
    @(negedge clk); rdy[0] = 1'b0;
    idle(1);

    // 7N2: second stop bit error, then async reset mid-frame
    rdy[3] = 1'b0;
    send_frame(3, 9'h05A, 7, 0, 1'b0, 2, 2'b01); idle(2);
    #1;
    chk("stop2_valid", 32'(vld[3]), 32'(1));
    chk("stop2_data", 32'(dout[3]), 32'h5A);
    chk("stop2_frame_err", 32'(ferr[3]), 32'(1));
    chk("stop2_parity_err", 32'(perr[3]), 32'(0));
    @(negedge clk);
    fork
      send_frame(3, 9'h033, 7, 0, 1'b0, 2, 2'b11);
      begin
        repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        #1;
        chk("pre_reset_busy", 32'(bsy[3]), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(vld[3]), 32'(0));
        chk("async_rst_data", 32'(dout[3]), 32'h0);
        chk("async_rst_frame_err", 32'(ferr[3]), 32'(0));
        chk("async_rst_busy", 32'(bsy[3]), 32'(0));
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    rdy[3] = 1'b1;
    idle(1);
    push(3, K_DATA, 8'h12, 1'b0, 1'b0);
    send_frame(3, 9'h012, 7, 0, 1'b0, 2, 2'b11); idle(2);

    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending events, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
